// File: rtl/bit_count_unit.sv
`default_nettype none
//==============================================================================
// Module      : bit_count_unit
// Description : Single-cycle CLZ / CTZ / popcount unit with optional left
//               normaliser (aligned, lz) enabled by BIT_COUNT_UNIT_ALIGN_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module bit_count_unit #(
    parameter int ORDER = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [1:0]              op,
    input  logic [(2**ORDER)-1:0]   in,
    output logic                    out_valid,
    output logic [ORDER:0]          count,
    output logic                    zero,
    output logic [(2**ORDER)-1:0]   aligned,
    output logic [ORDER:0]          lz
);

    localparam int             c_W      = 2**ORDER;
    localparam logic [ORDER:0] c_W_CNT  = (ORDER+1)'(c_W);
    localparam logic [1:0]     c_OP_CTZ  = 2'b01;
    localparam logic [1:0]     c_OP_PCNT = 2'b10;

    logic [c_W-1:0]   w_lnorm [0:ORDER];
    logic [ORDER-1:0] w_lshift;
    logic [c_W-1:0]   w_rnorm [0:ORDER-1];
    logic [ORDER-1:0] w_rshift;
    logic             w_zero;
    logic [ORDER:0]   w_clz;
    logic [ORDER:0]   w_ctz;
    logic [ORDER:0]   w_pc [1:2*c_W-1];
    logic [ORDER:0]   w_count;

    assign w_lnorm[0] = in;
    assign w_rnorm[0] = in;
    assign w_zero     = (in == '0);

    // Binary-search normalisers: each stage tests half of the remaining span
    // and contributes one bit of the leading/trailing zero count.
    generate
        for (genvar k = 0; k < ORDER; k++) begin : g_norm
            localparam int c_SH = 2**(ORDER-1-k);
            assign w_lshift[ORDER-1-k] = (w_lnorm[k][c_W-1 -: c_SH] == '0);
            assign w_lnorm[k+1] = w_lshift[ORDER-1-k] ? (w_lnorm[k] << c_SH) : w_lnorm[k];
            assign w_rshift[ORDER-1-k] = (w_rnorm[k][c_SH-1:0] == '0);
            if (k < ORDER-1) begin : g_rnext
                assign w_rnorm[k+1] = w_rshift[ORDER-1-k] ? (w_rnorm[k] >> c_SH) : w_rnorm[k];
            end
        end
    endgenerate

    // The search saturates at W-1 for an all-zero word, so zero is patched to W.
    assign w_clz = w_zero ? c_W_CNT : {1'b0, w_lshift};
    assign w_ctz = w_zero ? c_W_CNT : {1'b0, w_rshift};

    // Popcount adder tree in heap layout: leaves at W..2W-1, root at node 1.
    generate
        for (genvar i = 0; i < c_W; i++) begin : g_pc_leaf
            assign w_pc[c_W+i] = {{ORDER{1'b0}}, in[i]};
        end
        for (genvar n = 1; n < c_W; n++) begin : g_pc_node
            assign w_pc[n] = w_pc[2*n] + w_pc[2*n+1];
        end
    endgenerate

    always_comb begin
        w_count = w_clz;
        case (op)
            c_OP_CTZ:  w_count = w_ctz;
            c_OP_PCNT: w_count = w_pc[1];
            default:   w_count = w_clz;
        endcase
    end

    logic           r_out_valid;
    logic [ORDER:0] r_count;
    logic           r_zero;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_count     <= '0;
            r_zero      <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_count <= w_count;
                r_zero  <= w_zero;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign zero      = r_zero;

`ifdef BIT_COUNT_UNIT_ALIGN_EN
    logic [c_W-1:0] r_aligned;
    logic [ORDER:0] r_lz;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_aligned <= '0;
            r_lz      <= '0;
        end else if (in_valid) begin
            r_aligned <= w_lnorm[ORDER];
            r_lz      <= w_clz;
        end
    end

    assign aligned = r_aligned;
    assign lz      = r_lz;
`else
    logic [c_W-1:0] w_unused_norm;
    assign w_unused_norm = w_lnorm[ORDER];
    assign aligned = '0;
    assign lz      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_count_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_bit_count_unit
// Description : Self-checking bench for bit_count_unit (ORDER=3).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_bit_count_unit;

    localparam int ORDER = 3;
    localparam int W     = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [1:0]       op;
    logic [W-1:0]     in;
    logic             out_valid;
    logic [ORDER:0]   count;
    logic             zero;
    logic [W-1:0]     aligned;
    logic [ORDER:0]   lz;

    bit_count_unit #(.ORDER(ORDER)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .op        (op),
        .in        (in),
        .out_valid (out_valid),
        .count     (count),
        .zero      (zero),
        .aligned   (aligned),
        .lz        (lz)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the output registers should hold.
    logic           m_valid;
    logic [ORDER:0] m_count;
    logic           m_zero;
    logic [W-1:0]   m_aligned;
    logic [ORDER:0] m_lz;

    function automatic int ref_clz(input logic [W-1:0] v);
        int n = W;
        for (int i = 0; i < W; i++) if (v[i]) n = W - 1 - i;
        return n;
    endfunction

    function automatic int ref_ctz(input logic [W-1:0] v);
        int n = W;
        for (int i = W - 1; i >= 0; i--) if (v[i]) n = i;
        return n;
    endfunction

    function automatic int ref_pcnt(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out_valid"}, int'(out_valid), int'(m_valid));
        check({tag, ".count"},     int'(count),     int'(m_count));
        check({tag, ".zero"},      int'(zero),      int'(m_zero));
        check({tag, ".aligned"},   int'(aligned),   int'(m_aligned));
        check({tag, ".lz"},        int'(lz),        int'(m_lz));
    endtask

    // Drive one cycle's inputs, advance past the edge, update the model, compare.
    task automatic cycle(input logic rst, input logic v, input logic [1:0] o,
                         input logic [W-1:0] d, input string tag);
        int c;
        reset = rst; in_valid = v; op = o; in = d;
        @(posedge clock);
        if (rst) begin
            m_valid = 0; m_count = 0; m_zero = 0; m_aligned = 0; m_lz = 0;
        end else begin
            m_valid = v;
            if (v) begin
                case (o)
                    2'b01:   c = ref_ctz(d);
                    2'b10:   c = ref_pcnt(d);
                    default: c = ref_clz(d);
                endcase
                m_count = (ORDER+1)'(c);
                m_zero  = (d == 0);
`ifdef BIT_COUNT_UNIT_ALIGN_EN
                m_lz      = (ORDER+1)'(ref_clz(d));
                m_aligned = W'(int'(d) << ref_clz(d));
`else
                m_lz      = 0;
                m_aligned = 0;
`endif
            end
        end
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic [1:0]     op;
        logic [W-1:0]   din;
        logic [ORDER:0] exp_count;
        logic           exp_zero;
        logic [W-1:0]   exp_aligned;
        logic [ORDER:0] exp_lz;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{2'b00, 8'h00, 4'd8, 1'b1, 8'h00, 4'd8};
        vecs[1]  = '{2'b01, 8'h00, 4'd8, 1'b1, 8'h00, 4'd8};
        vecs[2]  = '{2'b10, 8'h00, 4'd0, 1'b1, 8'h00, 4'd8};
        vecs[3]  = '{2'b00, 8'h01, 4'd7, 1'b0, 8'h80, 4'd7};
        vecs[4]  = '{2'b01, 8'h28, 4'd3, 1'b0, 8'hA0, 4'd2};
        vecs[5]  = '{2'b10, 8'hB5, 4'd5, 1'b0, 8'hB5, 4'd0};
        vecs[6]  = '{2'b00, 8'hFF, 4'd0, 1'b0, 8'hFF, 4'd0};
        vecs[7]  = '{2'b10, 8'hFF, 4'd8, 1'b0, 8'hFF, 4'd0};
        vecs[8]  = '{2'b01, 8'h80, 4'd7, 1'b0, 8'h80, 4'd0};
        vecs[9]  = '{2'b11, 8'h01, 4'd7, 1'b0, 8'h80, 4'd7};
        vecs[10] = '{2'b00, 8'h10, 4'd3, 1'b0, 8'h80, 4'd3};

        reset = 1'b1; in_valid = 1'b0; op = 2'b00; in = '0;
        m_valid = 0; m_count = 0; m_zero = 0; m_aligned = 0; m_lz = 0;

        // Reset state
        cycle(1'b1, 1'b0, 2'b00, 8'h00, "reset");
        cycle(1'b1, 1'b0, 2'b00, 8'h00, "reset2");

        // Directed table
        for (int i = 0; i < 11; i++) begin
            logic [W-1:0]   ea;
            logic [ORDER:0] el;
            cycle(1'b0, 1'b1, vecs[i].op, vecs[i].din, $sformatf("vec%0d.model", i));
`ifdef BIT_COUNT_UNIT_ALIGN_EN
            ea = vecs[i].exp_aligned;
            el = vecs[i].exp_lz;
`else
            ea = '0;
            el = '0;
`endif
            check($sformatf("vec%0d.count", i),   int'(count),   int'(vecs[i].exp_count));
            check($sformatf("vec%0d.zero", i),    int'(zero),    int'(vecs[i].exp_zero));
            check($sformatf("vec%0d.aligned", i), int'(aligned), int'(ea));
            check($sformatf("vec%0d.lz", i),      int'(lz),      int'(el));
            check($sformatf("vec%0d.valid", i),   int'(out_valid), 1);
        end

        // Valid then idle: count holds
        cycle(1'b0, 1'b1, 2'b00, 8'h10, "hold_a");
        check("hold_a.count", int'(count), 3);
        cycle(1'b0, 1'b0, 2'b00, 8'hFF, "hold_b");
        check("hold_b.valid", int'(out_valid), 0);
        check("hold_b.count", int'(count), 3);

        // Reset wins over a simultaneous valid operand
        cycle(1'b1, 1'b1, 2'b10, 8'hFF, "rst_prio");
        check("rst_prio.valid", int'(out_valid), 0);
        check("rst_prio.count", int'(count), 0);
        cycle(1'b0, 1'b0, 2'b00, 8'h00, "post_rst");
        check("post_rst.valid", int'(out_valid), 0);

        // Exhaustive sweep, back-to-back, each op
        for (int o = 0; o < 4; o++)
            for (int d = 0; d < 256; d++)
                cycle(1'b0, 1'b1, 2'(o), 8'(d), $sformatf("sweep_op%0d_%02h", o, d));

        // Randomised traffic with gaps and occasional reset
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 49) == 0);
            cycle(r, 1'($urandom_range(0, 3) != 0), 2'($urandom),
                  8'($urandom), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
